// File: rtl/dmem_mmio_pkg.sv
// ---------------------------------------------------------------------------
// dmem_mmio_pkg
// Shared definitions for the data-side memory responder:
//   - byte offsets of the memory-mapped registers inside the MMIO window
//   - region enum produced by the address decoder
//   - decodeRegion(): classifies a byte address as RAM, MMIO or unmapped
// ---------------------------------------------------------------------------
package dmem_mmio_pkg;

  // Register offsets within the 16-byte MMIO window (addr[3:0])
  localparam logic [3:0] OFF_CYCLE  = 4'h0;
  localparam logic [3:0] OFF_CMP    = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_GPIO   = 4'hC;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  // RAM occupies [0, ramBytes); the MMIO window is the 16-byte block whose
  // upper 28 address bits match mmioBase. Everything else is unmapped.
  function automatic region_e decodeRegion(
    input logic [31:0] addr,
    input logic [31:0] ramBytes,
    input logic [31:0] mmioBase
  );
    if (addr < ramBytes) begin
      return REG_RAM;
    end else if (addr[31:4] == mmioBase[31:4]) begin
      return REG_MMIO;
    end else begin
      return REG_NONE;
    end
  endfunction

endpackage

// File: rtl/dmem_mmio_timer.sv
// ---------------------------------------------------------------------------
// mmio_timer
// Free-running cycle counter plus compare register and sticky match flag.
//   clk      in   clock
//   reset    in   synchronous active-high reset
//   cmpWe    in   load cmp from cmpWd on this edge
//   cmpWd    in   new compare value
//   flagClr  in   write-one-to-clear request for the match flag
//   cycle    out  current counter value
//   cmp      out  current compare value
//   flag     out  sticky match flag
// ---------------------------------------------------------------------------
module mmio_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmpWe,
  input  logic [31:0] cmpWd,
  input  logic        flagClr,
  output logic [31:0] cycle,
  output logic [31:0] cmp,
  output logic        flag
);

  logic [31:0] cycleReg;
  logic [31:0] cmpReg;
  logic        flagReg;
  logic        match;

  // Compare the values visible this cycle; a CMP write lands on the same
  // edge the match is sampled, so the old CMP is what gets compared.
  assign match = (cycleReg == cmpReg);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycleReg <= 32'd0;
      cmpReg   <= 32'hFFFF_FFFF;
      flagReg  <= 1'b0;
    end else begin
      cycleReg <= cycleReg + 32'd1;   // natural wrap FFFF_FFFF -> 0
      if (cmpWe) begin
        cmpReg <= cmpWd;
      end
      // A match in the same cycle as a clear keeps the flag set.
      if (match) begin
        flagReg <= 1'b1;
      end else if (flagClr) begin
        flagReg <= 1'b0;
      end
    end
  end

  assign cycle = cycleReg;
  assign cmp   = cmpReg;
  assign flag  = flagReg;

endmodule

// File: rtl/dmem_mmio.sv
// ---------------------------------------------------------------------------
// dmem_mmio
// Data-side memory responder for the pipelined MIPS core memory stage.
// Combinational read, byte-lane stores into a word RAM, and a small MMIO
// window holding a cycle counter, compare timer, status flag and GPIO.
//   clk       in   clock
//   reset     in   synchronous active-high reset (RAM is not cleared)
//   addr      in   byte address from the memory stage
//   we        in   write enable
//   sb        in   byte store qualifier for we
//   wd        in   write data
//   rd        out  read data, combinational from addr and current state
//   gpio_out  out  GPIO register contents
//   irq       out  sticky timer-match flag
// ---------------------------------------------------------------------------
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          GPIO_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic              sb,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  region_e           region;
  logic [IDX_W-1:0]  wordIdx;
  logic [3:0]        laneMask;
  logic [3:0][7:0]   laneData;
  logic              ramStore;
  logic              mmioStore;
  logic              cmpWe;
  logic              flagClr;
  logic              gpioWe;
  logic [GPIO_W-1:0] gpioReg;
  logic [31:0]       cycleVal;
  logic [31:0]       cmpVal;
  logic              flagVal;
  logic [31:0]       rdMux;

  logic [31:0] ramMem [DEPTH_WORDS];

  assign region  = decodeRegion(addr, RAM_BYTES, MMIO_BASE);
  assign wordIdx = addr[IDX_W+1:2];

  // Word stores enable all four lanes; byte stores enable only the lane
  // selected by addr[1:0] and replicate wd[7:0] onto it (little-endian).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign laneMask[gi] = !sb || (addr[1:0] == 2'(gi));
      assign laneData[gi] = sb ? wd[7:0] : wd[gi*8 +: 8];
    end
  endgenerate

  // Stores are suppressed while reset is held.
  assign ramStore  = we && !reset && (region == REG_RAM);
  // The register window only accepts full-word stores.
  assign mmioStore = we && !sb && !reset && (region == REG_MMIO);
  assign cmpWe     = mmioStore && (addr[3:0] == OFF_CMP);
  assign flagClr   = mmioStore && (addr[3:0] == OFF_STATUS) && wd[0];
  assign gpioWe    = mmioStore && (addr[3:0] == OFF_GPIO);

  always_ff @(posedge clk) begin
    if (ramStore) begin
      for (int i = 0; i < 4; i++) begin
        if (laneMask[i]) begin
          ramMem[wordIdx][i*8 +: 8] <= laneData[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpioReg <= '0;
    end else if (gpioWe) begin
      gpioReg <= wd[GPIO_W-1:0];
    end
  end

  mmio_timer uTimer (
    .clk     (clk),
    .reset   (reset),
    .cmpWe   (cmpWe),
    .cmpWd   (wd),
    .flagClr (flagClr),
    .cycle   (cycleVal),
    .cmp     (cmpVal),
    .flag    (flagVal)
  );

  // Read path: full word always; the core extracts bytes itself.
  always_comb begin
    rdMux = 32'd0;
    unique case (region)
      REG_RAM: begin
        rdMux = ramMem[wordIdx];
      end
      REG_MMIO: begin
        case (addr[3:0])
          OFF_CYCLE:  rdMux = cycleVal;
          OFF_CMP:    rdMux = cmpVal;
          OFF_STATUS: rdMux = {31'd0, flagVal};
          OFF_GPIO:   rdMux = 32'(gpioReg);
          default:    rdMux = 32'd0;
        endcase
      end
      default: begin
        rdMux = 32'd0;
      end
    endcase
  end

  assign rd       = rdMux;
  assign gpio_out = gpioReg;
  assign irq      = flagVal;

endmodule
